serial_tx: RTL and testbench



---
 rtl/serial_pkg.sv | 38 +++
 rtl/serial_tx.sv | 125 ++++++++++++
 tb/tb_serial_tx.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//
// Definitions shared by the UART transmit (serial_tx) and receive (serial_rx)
// blocks. Both sides agree on the frame shape and the line levels through
// this package, so a change here keeps the pair consistent.
//
// Contents:
//   DEFAULT_DATA_BITS  payload width used when a block is not overridden
//   DEFAULT_STOP_BITS  stop-bit periods used when a block is not overridden
//   LINE_IDLE          level of the serial line between frames (mark)
//   LINE_START         level of the start bit (space)
//   serial_state_e     frame state encoding shared by both directions
//   serial_cnt_width   width of a counter that must hold 0..n-1
// -----------------------------------------------------------------------------
package serial_pkg;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_STOP_BITS = 1;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Fixed encoding so the receive side and debug tooling can decode the
    // state register by value.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } serial_state_e;

    // Bits needed for a counter that runs 0..n-1; never narrower than 1 bit.
    function automatic int serial_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
//
// UART transmitter, N data bits, no parity, STOP_BITS stop bits, LSB first.
// A byte is taken on a valid/ready handshake and shifted out on tx_o, one bit
// per baud_rate_tick_i. The tick comes from a free-running baud generator
// shared with serial_rx, so the start bit lasts from accept to the first tick
// (up to one bit period plus phase error).
//
// Parameters:
//   DATA_BITS  payload width in bits (at least 2)
//   STOP_BITS  number of stop-bit periods (1 or 2)
//
// Ports:
//   sysclk            system clock, rising edge
//   reset_n           asynchronous active-low reset; aborts any frame
//   baud_rate_tick_i  one-sysclk pulse per bit period
//   data_i            byte to send, sampled only at the accept edge
//   valid_i           data_i valid, held by the source until accepted
//   ready_o           high while idle and able to accept a byte
//   tx_o              serial line, idle high, driven straight from a flop
//   busy_o            high from accept until the last stop period ends
// -----------------------------------------------------------------------------
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic                 baud_rate_tick_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    // One counter serves both the data bits and the stop periods, so it is
    // sized for whichever is longer.
    localparam int MAX_CNT = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int CNT_W   = serial_cnt_width(MAX_CNT);

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    serial_state_e        state;
    logic [DATA_BITS-1:0] shift;
    logic [CNT_W-1:0]     bit_cnt;

    // tx_o is always loaded with the level of the bit about to be on the
    // line, so it changes only on a clock edge and never glitches while the
    // state register updates. ready_o/busy_o are registered the same way.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            tx_o    <= LINE_IDLE;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_o <= LINE_IDLE;
                    // A tick on the accept edge is deliberately ignored: the
                    // start bit must span at least until the next tick.
                    if (valid_i && ready_o) begin
                        shift   <= data_i;
                        state   <= START;
                        tx_o    <= LINE_START;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                    end
                end

                START: begin
                    if (baud_rate_tick_i) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx_o    <= shift[0];
                    end
                end

                DATA: begin
                    if (baud_rate_tick_i) begin
                        shift <= shift >> 1;
                        if (bit_cnt == LAST_DATA) begin
                            state   <= STOP;
                            bit_cnt <= '0;
                            tx_o    <= LINE_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            // shift[1] becomes shift[0] on this same edge.
                            tx_o    <= shift[1];
                        end
                    end
                end

                STOP: begin
                    tx_o <= LINE_IDLE;
                    if (baud_rate_tick_i) begin
                        if (bit_cnt == LAST_STOP) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            ready_o <= 1'b1;
                            busy_o  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    tx_o    <= LINE_IDLE;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx
//
// Two transmitters share one stimulus: u_tx1 with one stop bit and u_tx2 with
// two. A frame-level model (tick count since accept -> line level) predicts
// ready/busy/tx for both on every cycle; directed sequences pin the model
// with hand-written bit patterns, frame lengths and reset behaviour.
// -----------------------------------------------------------------------------
module tb_serial_tx;

    localparam int DB = 8;

    logic       sysclk  = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick    = 1'b0;
    logic [7:0] data_i  = 8'h00;
    logic       valid_i = 1'b0;
    logic [1:0] tx_w;
    logic [1:0] ready_w;
    logic [1:0] busy_w;

    int checks = 0;
    int errors = 0;
    int tick_mode = 0;   // 0: every 4th cycle, 1: held high, 2: random
    int tick_div  = 0;

    always #5 sysclk = ~sysclk;

    serial_tx #(.DATA_BITS(DB), .STOP_BITS(1)) u_tx1 (
        .sysclk           (sysclk),
        .reset_n          (reset_n),
        .baud_rate_tick_i (tick),
        .data_i           (data_i),
        .valid_i          (valid_i),
        .ready_o          (ready_w[0]),
        .tx_o             (tx_w[0]),
        .busy_o           (busy_w[0])
    );

    serial_tx #(.DATA_BITS(DB), .STOP_BITS(2)) u_tx2 (
        .sysclk           (sysclk),
        .reset_n          (reset_n),
        .baud_rate_tick_i (tick),
        .data_i           (data_i),
        .valid_i          (valid_i),
        .ready_o          (ready_w[1]),
        .tx_o             (tx_w[1]),
        .busy_o           (busy_w[1])
    );

    // Baud tick source, changes on the falling edge.
    always @(negedge sysclk) begin
        case (tick_mode)
            0: begin
                tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
                tick     <= (tick_div == 3);
            end
            1:       tick <= 1'b1;
            default: tick <= ($urandom_range(0, 3) == 0);
        endcase
    end

    // ---------------- frame-level reference model ----------------
    logic       m_busy  [2];
    logic [7:0] m_byte  [2];
    int         m_ticks [2];

    function automatic int frame_len(input int i);
        return 1 + DB + (i + 1);
    endfunction

    always @(posedge sysclk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_busy[i]  <= 1'b0;
                m_byte[i]  <= 8'h00;
                m_ticks[i] <= 0;
            end else if (!m_busy[i]) begin
                if (valid_i) begin
                    m_busy[i]  <= 1'b1;
                    m_byte[i]  <= data_i;
                    m_ticks[i] <= 0;
                end
            end else if (tick) begin
                m_ticks[i] <= m_ticks[i] + 1;
                if (m_ticks[i] + 1 == frame_len(i)) m_busy[i] <= 1'b0;
            end
        end
    end

    // {ready, busy, tx} the line must show given ticks seen since accept.
    function automatic logic [2:0] model_out(input int i);
        if (!m_busy[i])          return 3'b101;
        if (m_ticks[i] == 0)     return 3'b010;
        if (m_ticks[i] <= DB)    return {2'b01, m_byte[i][m_ticks[i]-1]};
        return 3'b011;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge sysclk) begin
        for (int i = 0; i < 2; i++)
            check($sformatf("model dut%0d ready/busy/tx", i),
                  {29'd0, ready_w[i], busy_w[i], tx_w[i]}, {29'd0, model_out(i)});
    end

    // ---------------- directed helpers ----------------
    // Waits for the next edge carrying a tick, returns on the following negedge.
    task automatic wait_tick();
        int n = 0;
        while (1) begin
            @(posedge sysclk);
            if (tick) break;
            n++;
            if (n > 200) begin
                check("tick timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(negedge sysclk);
    endtask

    // Presents b and waits for the accept edge; gap = idle negedges waited.
    task automatic accept(input int idx, input logic [7:0] b, input logic keep, output int gap);
        gap = 0;
        data_i  = b;
        valid_i = 1'b1;
        while (!ready_w[idx] && gap < 200) begin
            @(negedge sysclk);
            gap++;
        end
        if (gap >= 200) check("accept timeout", 32'd1, 32'd0);
        @(posedge sysclk);
        @(negedge sysclk);
        if (!keep) valid_i = 1'b0;
        check("start bit one cycle after accept", {31'd0, tx_w[idx]}, 32'd0);
        check("ready low after accept", {31'd0, ready_w[idx]}, 32'd0);
        check("busy high after accept", {31'd0, busy_w[idx]}, 32'd1);
    endtask

    // Collects the data bits and counts tick periods until ready returns.
    task automatic receive(input int idx, input logic inject, input logic [7:0] inj_b,
                           output logic [7:0] got, output int ticks);
        ticks = 0;
        got   = 8'h00;
        wait_tick();
        ticks++;
        for (int k = 0; k < DB; k++) begin
            got[k] = tx_w[idx];
            if (inject && k == 3) begin
                valid_i = 1'b1;
                data_i  = inj_b;
                check("ready held low while busy", {31'd0, ready_w[idx]}, 32'd0);
            end
            wait_tick();
            ticks++;
        end
        while (!ready_w[idx] && ticks < 40) begin
            check("stop level", {31'd0, tx_w[idx]}, 32'd1);
            wait_tick();
            ticks++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ready_w != 2'b11 && n < 300) begin
            @(negedge sysclk);
            n++;
        end
        if (n >= 300) check("idle timeout", 32'd1, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] got;
        int ticks;
        int gap;
        int seq_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

        repeat (3) @(negedge sysclk);
        check("reset ready", {30'd0, ready_w}, 32'h3);
        check("reset busy",  {30'd0, busy_w},  32'h0);
        check("reset tx",    {30'd0, tx_w},    32'h3);
        reset_n = 1'b1;
        repeat (2) @(negedge sysclk);

        // A5, LSB first
        accept(0, 8'hA5, 1'b0, gap);
        receive(0, 1'b0, 8'h00, got, ticks);
        for (int k = 0; k < 8; k++)
            check($sformatf("A5 bit %0d", k), {31'd0, got[k]}, seq_a5[k]);
        check("A5 frame ticks", ticks, 10);
        check("A5 ready after stop", {31'd0, ready_w[0]}, 32'd1);
        wait_idle();

        // Back-to-back with valid held; next byte presented mid-frame
        accept(0, 8'h00, 1'b1, gap);
        data_i = 8'hFF;
        receive(0, 1'b0, 8'h00, got, ticks);
        check("b2b byte 00", got, 8'h00);
        accept(0, 8'hFF, 1'b1, gap);
        check("b2b gap FF", gap, 0);
        data_i = 8'h55;
        receive(0, 1'b0, 8'h00, got, ticks);
        check("b2b byte FF", got, 8'hFF);
        accept(0, 8'h55, 1'b0, gap);
        check("b2b gap 55", gap, 0);
        receive(0, 1'b0, 8'h00, got, ticks);
        check("b2b byte 55", got, 8'h55);
        wait_idle();

        // Valid raised with a new byte mid-frame
        accept(0, 8'h3C, 1'b0, gap);
        receive(0, 1'b1, 8'hC3, got, ticks);
        check("busy frame keeps 3C", got, 8'h3C);
        accept(0, 8'hC3, 1'b0, gap);
        check("C3 accepted at first idle", gap, 0);
        receive(0, 1'b0, 8'h00, got, ticks);
        check("C3 frame", got, 8'hC3);
        wait_idle();

        // Reset during data bit 4 of F0
        accept(0, 8'hF0, 1'b0, gap);
        repeat (5) wait_tick();
        check("F0 bit 4 on line", {31'd0, tx_w[0]}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async reset tx",    {30'd0, tx_w},    32'h3);
        check("async reset ready", {30'd0, ready_w}, 32'h3);
        check("async reset busy",  {30'd0, busy_w},  32'h0);
        @(negedge sysclk);
        reset_n = 1'b1;
        @(negedge sysclk);
        accept(0, 8'h81, 1'b0, gap);
        receive(0, 1'b0, 8'h00, got, ticks);
        check("81 after reset", got, 8'h81);
        wait_idle();

        // Two stop bits
        accept(1, 8'h01, 1'b0, gap);
        receive(1, 1'b0, 8'h00, got, ticks);
        check("2-stop byte", got, 8'h01);
        check("2-stop frame ticks", ticks, 11);
        wait_idle();

        // Tick held high
        tick_mode = 1;
        repeat (2) @(negedge sysclk);
        accept(0, 8'h96, 1'b0, gap);
        receive(0, 1'b0, 8'h00, got, ticks);
        check("fast byte 96", got, 8'h96);
        check("fast frame sysclks", ticks, 10);
        wait_idle();

        // Random traffic, random ticks, occasional mid-cycle reset
        tick_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            @(negedge sysclk);
            reset_n = 1'b1;
            valid_i = ($urandom_range(0, 2) != 0);
            data_i  = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset_n = 1'b0;
                #1;
                check("random async reset", {26'd0, ready_w, busy_w, tx_w}, {26'd0, 6'b110011});
            end
        end
        @(negedge sysclk);
        reset_n = 1'b1;
        valid_i = 1'b0;
        wait_idle();
        repeat (2) @(negedge sysclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
